// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed scan controller for a four-digit seven-segment display.
//   A 16-bit hex value, the digit-enable mask and the decimal points are
//   latched into shadow registers once per frame. The scanner then steps
//   through the four digits, holding each one for REFRESH_DIV cycles. The
//   first GUARD cycles of every slot keep all anodes off, which suppresses
//   ghosting between digits.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   GUARD        anode-off cycles at the start of each slot (1..REFRESH_DIV-1)
//   LZ_BLANK     1 = blank leading-zero digits (digit 0 is always shown)
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   value        hex value; digit i = value[4i+3:4i], digit 0 is rightmost
//   digit_en     per-digit enable, 1 = displayed
//   dp_in        per-digit decimal point, 1 = lit
//   digit_nibble nibble for the downstream hex-to-segment decoder
//   an           active-low anodes, an[i] drives digit i
//   dp           active-low decimal-point cathode
//   frame_start  one-cycle pulse, first cycle with newly latched shadow data
module seven_segment_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 1,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  digit_nibble,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_C  = PW'(GUARD);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   sval_q, sval_d;
  logic [3:0]    sen_q, sen_d;
  logic [3:0]    sdp_q, sdp_d;
  logic [3:0]    nib_q, nib_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          fs_q, fs_d;

  logic          load;
  logic          slot_end;
  logic [3:0]    nz;
  logic          supp;
  logic          lit;

  always_comb begin
    load     = (idx_q == 2'd0) && (pcnt_q == '0);
    slot_end = (pcnt_q == PCNT_MAX);

    pcnt_d = slot_end ? '0 : pcnt_q + PW'(1);
    idx_d  = slot_end ? idx_q + 2'd1 : idx_q;

    sval_d = load ? value    : sval_q;
    sen_d  = load ? digit_en : sen_q;
    sdp_d  = load ? dp_in    : sdp_q;

    // A digit is a leading zero when no nibble at its position or above is
    // nonzero; digit 0 is exempt so an all-zero value still shows "0".
    for (int i = 0; i < 4; i++) nz[i] = |sval_q[4*i +: 4];
    supp = LZ_BLANK && (idx_q != 2'd0) && ((nz >> idx_q) == 4'd0);

    lit = (pcnt_q >= GUARD_C) && sen_q[idx_q] && !supp;

    // Outputs are built from the current (pre-load) shadow; the load cycle is
    // always inside the guard window so the stale data is never lit.
    nib_d = sval_q[{idx_q, 2'b00} +: 4];
    an_d  = lit ? ~(4'b0001 << idx_q) : 4'b1111;
    dp_d  = lit ? ~sdp_q[idx_q] : 1'b1;
    fs_d  = load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      idx_q  <= 2'd0;
      sval_q <= 16'h0000;
      sen_q  <= 4'h0;
      sdp_q  <= 4'h0;
      nib_q  <= 4'h0;
      an_q   <= 4'b1111;
      dp_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      sval_q <= sval_d;
      sen_q  <= sen_d;
      sdp_q  <= sdp_d;
      nib_q  <= nib_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
      fs_q   <= fs_d;
    end
  end

  assign digit_nibble = nib_q;
  assign an           = an_q;
  assign dp           = dp_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;

  logic [3:0] nib0, an0, nib1, an1;
  logic       dp0, fs0, dp1, fs1;

  int checks   = 0;
  int failures = 0;
  int c        = 0;

  always #5 clk = ~clk;

  // dut0: no blanking, dut1: leading-zero blanking; both share the stimulus
  seven_segment_scanner #(.REFRESH_DIV(4), .GUARD(1), .LZ_BLANK(1'b0)) dut0 (
    .clk(clk), .reset(reset), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .digit_nibble(nib0), .an(an0), .dp(dp0), .frame_start(fs0));

  seven_segment_scanner #(.REFRESH_DIV(4), .GUARD(1), .LZ_BLANK(1'b1)) dut1 (
    .clk(clk), .reset(reset), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .digit_nibble(nib1), .an(an1), .dp(dp1), .frame_start(fs1));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    c++;
  endtask

  // One reset edge; on return the bench sits in cycle 0 with reset released.
  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c = 0;
  endtask

  // Runs cycles 1..16 after release. Per-slot expectations are packed as
  // {slot3, slot2, slot1, slot0}; guard cycles must have all anodes off.
  task automatic run_frame(input string tag,
                           input logic [15:0] an0_e, input logic [15:0] nib0_e, input logic [3:0] dp0_e,
                           input logic [15:0] an1_e, input logic [15:0] nib1_e, input logic [3:0] dp1_e,
                           input bit chg, input logic [15:0] chg_v);
    int slot;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk({tag, ".fs0"}, {15'd0, fs0}, (k == 1) ? 16'd1 : 16'd0);
      chk({tag, ".fs1"}, {15'd0, fs1}, (k == 1) ? 16'd1 : 16'd0);
      if ((k - 1) % 4 == 0) begin
        chk({tag, ".guard_an0"}, {12'd0, an0}, 16'h000f);
        chk({tag, ".guard_an1"}, {12'd0, an1}, 16'h000f);
        chk({tag, ".guard_dp0"}, {15'd0, dp0}, 16'd1);
      end else begin
        slot = (k - 1) / 4;
        chk({tag, ".an0"},  {12'd0, an0},  {12'd0, an0_e[4*slot +: 4]});
        chk({tag, ".nib0"}, {12'd0, nib0}, {12'd0, nib0_e[4*slot +: 4]});
        chk({tag, ".dp0"},  {15'd0, dp0},  {15'd0, dp0_e[slot]});
        chk({tag, ".an1"},  {12'd0, an1},  {12'd0, an1_e[4*slot +: 4]});
        chk({tag, ".nib1"}, {12'd0, nib1}, {12'd0, nib1_e[4*slot +: 4]});
        chk({tag, ".dp1"},  {15'd0, dp1},  {15'd0, dp1_e[slot]});
      end
      if (chg && c == 9) value = chg_v;
    end
  endtask

  initial begin
    reset    = 1'b1;
    value    = 16'h1234;
    digit_en = 4'b1111;
    dp_in    = 4'b0000;
    tick();
    tick();
    tick();
    chk("rst.an",  {12'd0, an0},  16'h000f);
    chk("rst.nib", {12'd0, nib0}, 16'h0000);
    chk("rst.dp",  {15'd0, dp0},  16'd1);
    chk("rst.fs",  {15'd0, fs0},  16'd0);

    // Basic scan, value changed to ABCD mid-frame (cycle 9)
    apply_reset();
    run_frame("basic", 16'h7BDE, 16'h1234, 4'b1111, 16'h7BDE, 16'h1234, 4'b1111, 1'b1, 16'hABCD);
    tick(); // cycle 17: new load visible as frame_start, still guard
    chk("basic.fs17",  {15'd0, fs0},  16'd1);
    chk("basic.an17",  {12'd0, an0},  16'h000f);
    chk("basic.nib17", {12'd0, nib0}, 16'h0004);
    for (int k = 18; k <= 20; k++) begin
      tick();
      chk("chg.an",  {12'd0, an0},  16'h000e);
      chk("chg.nib", {12'd0, nib0}, 16'h000d);
      chk("chg.fs",  {15'd0, fs0},  16'd0);
    end

    // Leading-zero blanking: 0070 and 0000
    value = 16'h0070;
    apply_reset();
    run_frame("lz70", 16'h7BDE, 16'h0070, 4'b1111, 16'hFFDE, 16'h0070, 4'b1111, 1'b0, 16'h0);
    value = 16'h0000;
    apply_reset();
    run_frame("lz00", 16'h7BDE, 16'h0000, 4'b1111, 16'hFFFE, 16'h0000, 4'b1111, 1'b0, 16'h0);

    // Enable mask and decimal point
    value    = 16'h1234;
    digit_en = 4'b0101;
    dp_in    = 4'b0100;
    apply_reset();
    run_frame("mask", 16'hFBFE, 16'h1234, 4'b1011, 16'hFBFE, 16'h1234, 4'b1011, 1'b0, 16'h0);

    // Reset during the digit-2 lit phase, then a clean restart
    digit_en = 4'b1111;
    dp_in    = 4'b0000;
    apply_reset();
    for (int k = 1; k <= 11; k++) tick();
    chk("mid.an_pre", {12'd0, an0}, 16'h000b);
    apply_reset();
    chk("mid.an",  {12'd0, an0},  16'h000f);
    chk("mid.dp",  {15'd0, dp0},  16'd1);
    chk("mid.nib", {12'd0, nib0}, 16'h0000);
    chk("mid.fs",  {15'd0, fs0},  16'd0);
    run_frame("restart", 16'h7BDE, 16'h1234, 4'b1111, 16'h7BDE, 16'h1234, 4'b1111, 1'b0, 16'h0);
    tick();
    chk("restart.fs17", {15'd0, fs0}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed scan controller for the Basys3 four-digit seven-segment display. It latches a 16-bit hex value once per frame and steps through the four digits at a programmable refresh rate. Each cycle it presents the selected 4-bit nibble to the downstream hex-to-segment decoder, and drives the active-low anodes and the decimal point. Options: per-digit enable mask, per-digit decimal point, leading-zero blanking, and an anode-off guard interval against ghosting.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz); legal range ≥ 2.
- GUARD, 1: cycles at the start of each slot with all anodes off; legal range 1..REFRESH_DIV-1.
- LZ_BLANK, 0: 1 = blank leading-zero digits.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- value  input  16  hex value; digit i = value[4i+3:4i], digit 0 rightmost.
- digit_en  input  4  per-digit enable, 1 = displayed.
- dp_in  input  4  per-digit decimal point, 1 = lit.
- digit_nibble  output  4  nibble for the downstream decoder.
- an  output  4  anodes, active low, an[i] = digit i.
- dp  output  1  decimal-point cathode, active low.
- frame_start  output  1  one-cycle pulse marking newly latched shadow contents.

## Operation
- State:
  - pcnt: prescaler, width $clog2(REFRESH_DIV), counts 0..REFRESH_DIV-1 and wraps.
  - idx: 2-bit digit index.
  - Shadow registers: sval (16 bits), sen (4 bits), sdp (4 bits).
- Slot advance: when pcnt == REFRESH_DIV-1, pcnt wraps to 0 and idx increments. Order is 0→1→2→3→0.
- Frame load: in the cycle where idx == 0 and pcnt == 0, sval/sen/sdp load from value/digit_en/dp_in. This includes the first cycle after reset release. Input changes between loads are invisible.
- Leading-zero rule (LZ_BLANK=1):
  - Digit i is suppressed if i > h, where h is the index of the highest nonzero nibble of sval.
  - Digit 0 is never suppressed by this rule.
  - LZ_BLANK=0: no suppression.
- Digit i is lit when all of the following hold: idx == i, pcnt ≥ GUARD, sen[i] == 1, and i is not suppressed.
- Output registers, computed each cycle from the current state:
  - digit_nibble = sval[4·idx+3:4·idx], always driven (also during guard or when blanked).
  - an = ~onehot(idx) if the digit is lit, else 4'b1111.
  - dp = ~sdp[idx] if the digit is lit, else 1.
  - frame_start = 1 in the cycle after the load cycle, else 0.

## Timing
- All outputs are registered, one cycle behind state. Load-cycle outputs use the old shadow. Because GUARD ≥ 1, no anode is lit during the load cycle, so stale data is never shown.
- Frame period = 4·REFRESH_DIV cycles.
- Lit time per slot = REFRESH_DIV-GUARD cycles.
- Reset: while reset is high, at each clock edge:
  - pcnt=0, idx=0, shadow=0.
  - an=4'b1111, digit_nibble=4'h0, dp=1, frame_start=0.
  - Reset mid-slot aborts the scan the next edge; no partial slot completes.
- After release, the first load occurs in the first non-reset cycle, and frame_start pulses one cycle later.
- Wrap from idx 3 to 0 and the next load coincide, with no idle cycle.
- A value change in the load cycle is captured; a change one cycle later waits a full frame.
- frame_start pulses exactly once per frame, 4·REFRESH_DIV cycles apart.

## Test plan
All scenarios use REFRESH_DIV=4 and GUARD=1. "Cycle n" counts from the first cycle after reset release, numbered 0.

- Basic scan. Stimulus: value=16'h1234, digit_en=4'b1111, dp_in=0.
  - Cycle 1: frame_start=1, an=1111.
  - Cycles 2-4: an=1110, digit_nibble=4.
  - Cycle 5: an=1111, digit_nibble=3.
  - Cycles 6-8: an=1101, nibble 3.
  - Cycles 10-12: an=1011, nibble 2.
  - Cycles 14-16: an=0111, nibble 1.
  - Cycle 17: frame_start=1.
- Mid-frame change. Change value to 16'hABCD at cycle 9.
  - Cycles 10-16 still show 2, 1.
  - Cycles 18-20 show nibble D.
- Leading-zero blanking, LZ_BLANK=1.
  - value=16'h0070: an stays 1111 during the idx 2 and idx 3 slots; digit 1 shows 7, digit 0 shows 0.
  - value=16'h0000: only digit 0 lit, showing 0.
- Enable mask and dp.
  - digit_en=4'b0101, dp_in=4'b0100: an is never 1101 or 0111; dp=0 only in cycles with an=1011.
- Reset mid-operation. Assert reset for one cycle during the digit-2 lit phase.
  - Next cycle: an=1111, dp=1, digit_nibble=0, frame_start=0.
  - After release, the sequence restarts exactly as in scenario 1.
